// File: rtl/l1_data_cache_if.sv
// CPU-side request/response and memory-side transfer signals of the L1 data cache.
// slave = cache side, master = requester/memory side.
interface l1_data_cache_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  read_enable;
  logic                  write_enable;
  logic [ADDR_WIDTH-1:0] request_address;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] response_data;
  logic [1:0]            c_state;
  logic [DATA_WIDTH-1:0] mem_response_data;
  logic                  mem_ready;
  logic                  mem_request;
  logic                  mem_write_enable;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_write_data;

  modport slave (
    input  read_enable, write_enable, request_address, write_data,
    input  mem_response_data, mem_ready,
    output response_data, c_state,
    output mem_request, mem_write_enable, mem_address, mem_write_data
  );

  modport master (
    output read_enable, write_enable, request_address, write_data,
    output mem_response_data, mem_ready,
    input  response_data, c_state,
    input  mem_request, mem_write_enable, mem_address, mem_write_data
  );
endinterface

// File: rtl/l1_data_cache.sv
// 2-way set-associative, one-word-line, write-back L1 data cache with per-set LRU bit.
// L1D_WRITE_ALLOCATE_EN: write misses allocate; otherwise they go straight to memory.
module l1_data_cache #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SETS   = 512
) (
  input logic           clk,
  input logic           reset,
  l1_data_cache_if.slave bus
);
  localparam int IW  = $clog2(NUM_SETS);
  localparam int WAW = ADDR_WIDTH - 2;
  localparam int TW  = WAW - IW;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [WAW-1:0]        waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  is_wr_q, is_wr_d;
  logic                  victim_q, victim_d;
  logic                  nowa_q, nowa_d;
  logic [DATA_WIDTH-1:0] resp_q, resp_d;
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
  logic [DATA_WIDTH-1:0] mwdata_q, mwdata_d;

  logic [1:0]            valid_q [NUM_SETS];
  logic [1:0]            dirty_q [NUM_SETS];
  logic                  lru_q   [NUM_SETS];
  logic [TW-1:0]         tag_q   [2][NUM_SETS];
  logic [DATA_WIDTH-1:0] data_q  [2][NUM_SETS];

  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic [1:0]    hit_way;
  logic          hit, hway, vsel;
  logic          upd_hit, fill;
  logic          unused_addr_lsbs;

  assign unused_addr_lsbs = ^bus.request_address[1:0];

  assign idx     = waddr_q[IW-1:0];
  assign tag     = waddr_q[WAW-1:IW];
  assign hit_way = {valid_q[idx][1] && (tag_q[1][idx] == tag),
                    valid_q[idx][0] && (tag_q[0][idx] == tag)};
  assign hit     = |hit_way;
  assign hway    = hit_way[1];
  assign vsel    = !valid_q[idx][0] ? 1'b0 :
                   !valid_q[idx][1] ? 1'b1 : lru_q[idx];

  always_comb begin
    state_d  = state_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    is_wr_d  = is_wr_q;
    victim_d = victim_q;
    nowa_d   = nowa_q;
    resp_d   = resp_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    upd_hit  = 1'b0;
    fill     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.write_enable || bus.read_enable) begin
          waddr_d = bus.request_address[ADDR_WIDTH-1:2];
          wdata_d = bus.write_data;
          is_wr_d = bus.write_enable;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (hit) begin
          upd_hit = 1'b1;
          if (!is_wr_q) resp_d = data_q[hway][idx];
          state_d = IDLE;
        end else
`ifndef L1D_WRITE_ALLOCATE_EN
        if (is_wr_q) begin
          // Write miss bypasses the cache: reuse the WRITEBACK transfer, then finish.
          nowa_d   = 1'b1;
          maddr_d  = {2'b00, waddr_q};
          mwdata_d = wdata_q;
          state_d  = WRITEBACK;
        end else
`endif
        begin
          nowa_d   = 1'b0;
          victim_d = vsel;
          if (dirty_q[idx][vsel]) begin
            maddr_d  = {2'b00, tag_q[vsel][idx], idx};
            mwdata_d = data_q[vsel][idx];
            state_d  = WRITEBACK;
          end else begin
            maddr_d  = {2'b00, waddr_q};
            state_d  = ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        if (bus.mem_ready) begin
          if (nowa_q) begin
            state_d = IDLE;
          end else begin
            maddr_d = {2'b00, waddr_q};
            state_d = ALLOCATE;
          end
        end
      end
      ALLOCATE: begin
        if (bus.mem_ready) begin
          fill    = 1'b1;
          state_d = COMPARE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      waddr_q  <= '0;
      wdata_q  <= '0;
      is_wr_q  <= 1'b0;
      victim_q <= 1'b0;
      nowa_q   <= 1'b0;
      resp_q   <= '0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        lru_q[s]   <= 1'b0;
      end
    end else begin
      state_q  <= state_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      is_wr_q  <= is_wr_d;
      victim_q <= victim_d;
      nowa_q   <= nowa_d;
      resp_q   <= resp_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      if (upd_hit) begin
        lru_q[idx] <= ~hway;
        if (is_wr_q) dirty_q[idx][hway] <= 1'b1;
      end
      if (fill) begin
        valid_q[idx][victim_q] <= 1'b1;
        dirty_q[idx][victim_q] <= 1'b0;
      end
    end
  end

  // Tag/data storage is qualified by valid bits, so it needs no reset.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[victim_q][idx]  <= tag;
      data_q[victim_q][idx] <= bus.mem_response_data;
    end
    if (upd_hit && is_wr_q) data_q[hway][idx] <= wdata_q;
  end

  assign bus.response_data    = resp_q;
  assign bus.c_state          = state_q;
  assign bus.mem_request      = (state_q == WRITEBACK) || (state_q == ALLOCATE);
  assign bus.mem_write_enable = (state_q == WRITEBACK);
  assign bus.mem_address      = maddr_q;
  assign bus.mem_write_data   = mwdata_q;
endmodule

// File: tb/tb_l1_data_cache.sv
// Bench for l1_data_cache: memory responder with fixed latency, golden memory image,
// and queues of expected load data and expected memory writes.
module tb_l1_data_cache;
  localparam int unsigned LAT   = 2;
  localparam int unsigned HIT   = 2;
  localparam int unsigned MISS  = 3 + LAT;
  localparam int unsigned DMISS = 3 + 2 * LAT;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  l1_data_cache_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  l1_data_cache #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SETS(512)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  logic [31:0] backing [logic [31:0]];
  logic [31:0] golden  [logic [31:0]];
  logic [31:0] exp_rd_q [$];
  logic [63:0] exp_wb_q [$];

  function automatic logic [31:0] dflt(input logic [31:0] w);
    return {w[15:0] ^ 16'h5A5A, w[15:0]};
  endfunction

  function automatic logic [31:0] bk_rd(input logic [31:0] w);
    return backing.exists(w) ? backing[w] : dflt(w);
  endfunction

  function automatic logic [31:0] gd_rd(input logic [31:0] w);
    return golden.exists(w) ? golden[w] : dflt(w);
  endfunction

  task automatic preload(input logic [31:0] w, input logic [31:0] d);
    backing[w] = d;
    golden[w]  = d;
  endtask

  // Memory: answers each transfer LAT cycles after mem_request is first seen.
  int unsigned rcnt;
  initial begin
    logic [63:0] e;
    bus.mem_ready = 1'b0;
    bus.mem_response_data = '0;
    rcnt = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        bus.mem_ready = 1'b0;
        rcnt = 0;
      end else begin
        if (bus.mem_ready) begin
          bus.mem_ready = 1'b0;
          rcnt = 0;
        end
        if (bus.mem_request) begin
          rcnt++;
          if (rcnt == LAT) begin
            bus.mem_ready = 1'b1;
            if (bus.mem_write_enable) begin
              backing[bus.mem_address] = bus.mem_write_data;
              if (exp_wb_q.size() == 0) begin
                check("wb_unexpected", bus.mem_address, 32'hFFFF_FFFF);
              end else begin
                e = exp_wb_q.pop_front();
                check("wb_addr", bus.mem_address, e[63:32]);
                check("wb_data", bus.mem_write_data, e[31:0]);
              end
            end else begin
              bus.mem_response_data = bk_rd(bus.mem_address);
            end
          end
        end
      end
    end
  end

  task automatic cpu_op(input string tag, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, input int unsigned exp_cyc,
                        output logic [15:0] seq);
    int unsigned cyc;
    int unsigned reqs;
    logic [1:0] last;
    logic [31:0] e;
    cyc = 0;
    reqs = 0;
    seq = '0;
    last = 2'd0;
    @(negedge clk);
    bus.request_address = addr;
    bus.write_data = wd;
    if (wr) begin
      bus.write_enable = 1'b1;
      golden[addr >> 2] = wd;
    end else begin
      bus.read_enable = 1'b1;
      exp_rd_q.push_back(gd_rd(addr >> 2));
    end
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        bus.read_enable = 1'b0;
        bus.write_enable = 1'b0;
      end
      if (bus.mem_request) reqs++;
      if (bus.c_state != last) begin
        seq = {seq[11:0], 2'b00, bus.c_state};
        last = bus.c_state;
      end
    end while (bus.c_state != 2'd0 && cyc < 200);
    if (cyc >= 200) check({tag, "_timeout"}, cyc, 0);
    check({tag, "_cycles"}, cyc, exp_cyc);
    if (exp_cyc == HIT) check({tag, "_memreq"}, reqs, 0);
    if (!wr) begin
      e = exp_rd_q.pop_front();
      check({tag, "_data"}, bus.response_data, e);
    end
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input int unsigned exp_cyc);
    logic [15:0] s;
    cpu_op(tag, 1'b0, addr, 32'h0, exp_cyc, s);
  endtask

  task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] d,
                    input int unsigned exp_cyc);
    logic [15:0] s;
    cpu_op(tag, 1'b1, addr, d, exp_cyc, s);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] seq;
    int unsigned w;
    bus.read_enable = 1'b0;
    bus.write_enable = 1'b0;
    bus.request_address = '0;
    bus.write_data = '0;
    preload(32'd512, 32'hAAAA_AAAA);
    preload(32'h2AF3_7A00, 32'hBBBB_BBBB);
    preload(32'd1023, 32'h1111_1111);

    #12;
    check("rst_state", bus.c_state, 2'd0);
    check("rst_resp", bus.response_data, 32'h0);
    check("rst_memreq", bus.mem_request, 1'b0);
    check("rst_memwe", bus.mem_write_enable, 1'b0);
    check("rst_memaddr", bus.mem_address, 32'h0);
    check("rst_memwdata", bus.mem_write_data, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Set 0: fill both ways, hits, LRU eviction.
    cpu_op("s0_a_miss", 1'b0, 32'h0000_0802, 32'h0, MISS, seq);
    check("s0_a_stateseq", seq, 16'h1310);
    rd("s0_b_miss", 32'hABCD_E802, MISS);
    rd("s0_a_hit", 32'h0000_0802, HIT);
    rd("s0_b_hit", 32'hABCD_E802, HIT);
    rd("s0_c_miss", 32'hAAAA_A802, MISS);
    rd("s0_b_hit2", 32'hABCD_E802, HIT);
    rd("s0_a_remiss", 32'h0000_0802, MISS);

    // Set 511: same sequence at the top index.
    rd("s511_a_miss", 32'h0000_0FFF, MISS);
    rd("s511_b_miss", 32'hABCD_EFFF, MISS);
    rd("s511_a_hit", 32'h0000_0FFF, HIT);
    rd("s511_b_hit", 32'hABCD_EFFF, HIT);
    rd("s511_c_miss", 32'hAAAA_AFFF, MISS);
    rd("s511_b_hit2", 32'hABCD_EFFF, HIT);
    rd("s511_a_remiss", 32'h0000_0FFF, MISS);

    // Dirty eviction: write hit, then two more tags in set 12 force a writeback.
    rd("s12_b_miss", 32'hABCD_E832, MISS);
    wr("s12_b_wrhit", 32'hABCD_E832, 32'hBEEF_DEAD, HIT);
    rd("s12_b_rdhit", 32'hABCD_E832, HIT);
    rd("s12_c_miss", 32'hAAAA_A832, MISS);
    exp_wb_q.push_back({32'h2AF3_7A0C, 32'hBEEF_DEAD});
    rd("s12_f_dirtymiss", 32'hFFFF_F832, DMISS);
    rd("s12_b_refill", 32'hABCD_E832, MISS);

    // Write miss.
`ifdef L1D_WRITE_ALLOCATE_EN
    wr("wmiss", 32'h0000_1010, 32'h1234_5678, MISS);
    rd("wmiss_rd", 32'h0000_1010, HIT);
`else
    exp_wb_q.push_back({32'h0000_0404, 32'h1234_5678});
    wr("wmiss", 32'h0000_1010, 32'h1234_5678, 2 + LAT);
    rd("wmiss_rd", 32'h0000_1010, MISS);
`endif
    check("wb_pending", exp_wb_q.size(), 0);

    // Reset in the middle of an allocate.
    @(negedge clk);
    bus.request_address = 32'h1234_5802;
    bus.read_enable = 1'b1;
    w = 0;
    while (bus.c_state != 2'd3 && w < 50) begin
      @(negedge clk);
      w++;
      if (bus.c_state != 2'd0) bus.read_enable = 1'b0;
    end
    check("alloc_reached", bus.c_state, 2'd3);
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_state", bus.c_state, 2'd0);
    check("mid_rst_memreq", bus.mem_request, 1'b0);
    check("mid_rst_memaddr", bus.mem_address, 32'h0);
    check("mid_rst_resp", bus.response_data, 32'h0);
    bus.read_enable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    rd("post_rst_miss", 32'hABCD_E802, MISS);
    rd("post_rst_hit", 32'hABCD_E802, HIT);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
